// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 16-bit adder among
// N_REQ valid/ready requesters, with a registered tagged response.

module sixteen_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [16:0] c;

  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    sum  = prop ^ c[15:0];
    cout = c[16];
  end

endmodule

module adder_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         st_q, st_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [IDW-1:0] id_q, id_d;

  logic [IDW-1:0] gnt;
  logic [IDW-1:0] lo_gnt;
  logic [IDW-1:0] hi_gnt;
  logic           hi_found;
  logic           any_vld;
  logic           can_accept;
  logic           grant_ok;
  logic           accept;

  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic           op_cin;
  logic [15:0]    add_sum;
  logic           add_cout;

  // Prefer the lowest valid index at or above ptr, else wrap to the lowest.
  always_comb begin
    lo_gnt   = '0;
    hi_gnt   = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_gnt = IDW'(i);
      end
      if (req_valid[i] && (IDW'(i) >= ptr_q)) begin
        hi_gnt   = IDW'(i);
        hi_found = 1'b1;
      end
    end
    gnt = hi_found ? hi_gnt : lo_gnt;
  end

  assign any_vld    = |req_valid;
  assign can_accept = (st_q == EMPTY) || rsp_ready;
  assign grant_ok   = !rst && can_accept && any_vld;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_ok && (gnt == IDW'(i));
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        op_a   = req_a[16*i +: 16];
        op_b   = req_b[16*i +: 16];
        op_cin = req_cin[i];
      end
    end
  end

  sixteen_adder u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    id_d   = id_q;
    unique case (st_q)
      EMPTY: begin
        if (accept) begin
          st_d = FULL;
        end
      end
      FULL: begin
        if (rsp_ready && !accept) begin
          st_d = EMPTY;
        end
      end
      default: st_d = EMPTY;
    endcase
    if (accept) begin
      sum_d  = add_sum;
      cout_d = add_cout;
      id_d   = gnt;
      ptr_d  = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= EMPTY;
      ptr_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      id_q   <= id_d;
    end
  end

  assign rsp_valid = (st_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus randomized traffic
// checked against a queue-free round-robin reference model.

module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_a;
  logic [16*N-1:0]  req_b;
  logic [N-1:0]     req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_sum;
  logic             rsp_cout;
  logic [IDW-1:0]   rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  int           m_ptr;
  bit           m_full;
  logic [15:0]  m_sum;
  logic         m_cout;
  int           m_id;
  logic [N-1:0] m_acc;

  adder_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    int i;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    logic [N-1:0] one;
    one = 1;
    g = m_grant();
    if (rst || (m_full && !rsp_ready) || g < 0) return '0;
    return one << g;
  endfunction

  function automatic logic [16:0] lane_sum(int i);
    return {1'b0, req_a[16*i +: 16]} + {1'b0, req_b[16*i +: 16]}
           + 17'(req_cin[i]);
  endfunction

  task automatic set_lane(int i, logic [15:0] a, logic [15:0] b,
                          logic c);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i] = c;
  endtask

  task automatic rand_lane(int i);
    set_lane(i, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Advance one clock; the model applies the edge from pre-edge inputs.
  task automatic tick();
    logic [16:0] s;
    int g;
    g = m_grant();
    m_acc = m_ready() & req_valid;
    if (rst) begin
      m_ptr = 0; m_full = 0; m_sum = '0; m_cout = 0; m_id = 0;
    end else if (m_acc != '0) begin
      s = lane_sum(g);
      m_sum = s[15:0]; m_cout = s[16]; m_id = g;
      m_full = 1; m_ptr = (g + 1) % N;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rsp_ready = 1; req_valid = '1;
    for (int i = 0; i < N; i++) rand_lane(i);
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tick(); tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (rsp_sum !== 16'h0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%b/%0d want 0000/0/0",
               rsp_sum, rsp_cout, rsp_id);
    end
    rst = 0; req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1; req_valid = 4'b0001;
    set_lane(0, 16'h0000, 16'hFFFF, 1'b0);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1 || rsp_sum !== 16'hFFFF || rsp_cout !== 0 ||
        rsp_id !== 0) begin
      n_bad++;
      $display("FAIL single_ffff: got v%b %h/%b/%0d want v1 FFFF/0/0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    set_lane(0, 16'h0001, 16'hFFFF, 1'b0);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_ready2: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1 || rsp_sum !== 16'h0000 || rsp_cout !== 1 ||
        rsp_id !== 0) begin
      n_bad++;
      $display("FAIL single_wrap: got v%b %h/%b/%0d want v1 0000/1/0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if (rsp_valid !== 0 || rsp_sum !== 16'h0000 || rsp_cout !== 1) begin
      n_bad++;
      $display("FAIL drain_hold: got v%b %h/%b want v0 0000/1",
               rsp_valid, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_carry_in();
    req_valid = 4'b0100;
    set_lane(2, 16'h8844, 16'h6280, 1'b1);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100 || rsp_valid !== 0) begin
      n_bad++;
      $display("FAIL cin_ready: got %b v%b want 0100 v0",
               req_ready, rsp_valid);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1 || rsp_sum !== 16'hEAC5 || rsp_cout !== 0 ||
        rsp_id !== 2) begin
      n_bad++;
      $display("FAIL cin_sum: got v%b %h/%b/%0d want v1 EAC5/0/2",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [16:0] s;
    logic [N-1:0] one;
    int e;
    one = 1;
    rst = 1; tick(); rst = 0;
    rsp_ready = 1; req_valid = '1;
    for (int i = 0; i < N; i++) rand_lane(i);
    for (int k = 0; k < 12; k++) begin
      e = k % N;
      #1;
      n_cmp++;
      if (req_ready !== (one << e)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b",
                 k, req_ready, one << e);
      end
      s = lane_sum(e);
      tick();
      n_cmp++;
      if (rsp_valid !== 1 || rsp_id !== IDW'(e) ||
          {rsp_cout, rsp_sum} !== s) begin
        n_bad++;
        $display("FAIL rr_rsp[%0d]: got v%b id%0d %h want v1 id%0d %h",
                 k, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, e, s);
      end
      rand_lane(e);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] hs;
    logic hc;
    logic [16:0] s;
    rsp_ready = 1; req_valid = 4'b0001; rand_lane(0);
    s = lane_sum(0);
    tick();
    hs = s[15:0]; hc = s[16];
    rsp_ready = 0; req_valid = 4'b1010;
    rand_lane(1); rand_lane(3);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1 || rsp_sum !== hs || rsp_cout !== hc ||
          rsp_id !== 0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v%b %h/%b/%0d want v1 %h/%b/0",
                 k, rsp_valid, rsp_sum, rsp_cout, rsp_id, hs, hc);
      end
    end
    rsp_ready = 1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL bp_release: got %b want 0010", req_ready);
    end
    s = lane_sum(1);
    tick();
    n_cmp++;
    if (rsp_valid !== 1 || rsp_id !== 1 || {rsp_cout, rsp_sum} !== s) begin
      n_bad++;
      $display("FAIL bp_next: got v%b id%0d %h want v1 id1 %h",
               rsp_valid, rsp_id, {rsp_cout, rsp_sum}, s);
    end
  endtask

  task automatic test_pointer_fairness();
    req_valid = 4'b1001; rand_lane(0);
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL ptr_first: got %b want 1000", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_id !== 3) begin
      n_bad++; $display("FAIL ptr_id3: got %0d want 3", rsp_id);
    end
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL ptr_second: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_id !== 0) begin
      n_bad++; $display("FAIL ptr_id0: got %0d want 0", rsp_id);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1; req_valid = 4'b0100; rand_lane(2);
    tick();
    rsp_ready = 0; req_valid = 4'b1010; rand_lane(1); rand_lane(3);
    rst = 1;
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++; $display("FAIL rstmid_ready: got %b want 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 0 || rsp_sum !== 16'h0 || rsp_cout !== 0 ||
        rsp_id !== 0) begin
      n_bad++;
      $display("FAIL rstmid_out: got v%b %h/%b/%0d want v0 0000/0/0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rst = 0; rsp_ready = 1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL rstmid_grant: got %b want 0010", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1 || rsp_id !== 1) begin
      n_bad++;
      $display("FAIL rstmid_id: got v%b id%0d want v1 id1",
               rsp_valid, rsp_id);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(99) < 2);
      rsp_ready = ($urandom_range(99) < 70);
      for (int i = 0; i < N; i++) begin
        if (m_acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(99) < 60);
          rand_lane(i);
        end
      end
      #1;
      exp_rdy = m_ready();
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL rnd_ready[%0d]: got %b want %b",
                 k, req_ready, exp_rdy);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== m_full || rsp_sum !== m_sum ||
          rsp_cout !== m_cout || rsp_id !== IDW'(m_id)) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: got v%b %h/%b/%0d want v%b %h/%b/%0d",
                 k, rsp_valid, rsp_sum, rsp_cout, rsp_id,
                 m_full, m_sum, m_cout, m_id);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; rsp_ready = 0; req_valid = '0;
    req_a = '0; req_b = '0; req_cin = '0;
    m_ptr = 0; m_full = 0; m_sum = '0; m_cout = 0; m_id = 0; m_acc = '0;
    test_reset();
    test_single();
    test_carry_in();
    test_round_robin();
    test_backpressure();
    test_pointer_fairness();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
